// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - operand sequencer and control initiator for one mac dot-product job (option: MAC_SEQ_REQUANT_EN)
module mac_seq #(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 22,
    parameter int ADDR_WIDTH = 8,
    parameter int SHIFT      = 8
) (
    input  logic                  clk,
    input  logic                  rst_mem,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic [ADDR_WIDTH-1:0] img_base,
    input  logic [ADDR_WIDTH-1:0] wgt_base,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] img_addr,
    output logic [ADDR_WIDTH-1:0] wgt_addr,
    input  logic [IN_WIDTH-1:0]   img_rdata,
    input  logic [IN_WIDTH-1:0]   wgt_rdata,
    output logic                  mac_rst_mem,
    output logic                  mac_mul_en,
    output logic                  mac_ac_en,
    output logic [IN_WIDTH-1:0]   mac_img,
    output logic [IN_WIDTH-1:0]   mac_weight,
    input  logic [OUT_WIDTH-1:0]  mac_acc,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] img_base_q;
    logic [ADDR_WIDTH-1:0] wgt_base_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [1:0]            drain_q;
    logic                  mul_en_q;
    logic                  ac_en_q;
    logic [OUT_WIDTH-1:0]  result_q;
    logic [OUT_WIDTH-1:0]  acc_f;

    logic run_last;
    logic drain_last;

    assign run_last   = (cnt_q == (len_q - ADDR_WIDTH'(1)));
    assign drain_last = (drain_q == 2'd2);

`ifdef MAC_SEQ_REQUANT_EN
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'((1 << IN_WIDTH) - 1);
    logic [OUT_WIDTH-1:0] acc_shifted;

    assign acc_shifted = mac_acc >> SHIFT;
    assign acc_f       = (acc_shifted > SAT_MAX) ? SAT_MAX : acc_shifted;
`else
    assign acc_f = mac_acc;
`endif

    // State register: reset from any state returns to IDLE, discarding the job
    always_ff @(posedge clk) begin
        if (rst_mem) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: CLEAR -> RUN (N cycles) -> DRAIN (3 cycles) -> HOLD until handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = (len_q != '0) ? S_RUN : S_DRAIN;
            S_RUN:   if (run_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_last) state_d = S_HOLD;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: read strobe only in RUN, MAC cleared in CLEAR or while in reset
    always_comb begin
        mem_rd_en   = (state_q == S_RUN);
        busy        = (state_q != S_IDLE);
        out_valid   = (state_q == S_HOLD);
        mac_rst_mem = rst_mem | (state_q == S_CLEAR);
    end

    // Job parameters, RUN index, DRAIN counter and the captured result
    always_ff @(posedge clk) begin
        if (rst_mem) begin
            len_q      <= '0;
            img_base_q <= '0;
            wgt_base_q <= '0;
            cnt_q      <= '0;
            drain_q    <= '0;
            result_q   <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                len_q      <= len;
                img_base_q <= img_base;
                wgt_base_q <= wgt_base;
            end
            case (state_q)
                S_CLEAR: begin
                    cnt_q   <= '0;
                    drain_q <= '0;
                end
                S_RUN: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                    if (drain_last) begin
                        result_q <= acc_f;
                    end
                end
                default: ;
            endcase
        end
    end

    // Enable pipeline: read data arrives one cycle after the strobe, the product one cycle later
    always_ff @(posedge clk) begin
        if (rst_mem) begin
            mul_en_q <= 1'b0;
            ac_en_q  <= 1'b0;
        end else begin
            mul_en_q <= mem_rd_en;
            ac_en_q  <= mul_en_q;
        end
    end

    // Addresses wrap naturally at the address width
    assign img_addr   = img_base_q + cnt_q;
    assign wgt_addr   = wgt_base_q + cnt_q;
    assign mac_mul_en = mul_en_q;
    assign mac_ac_en  = ac_en_q;
    assign mac_img    = img_rdata;
    assign mac_weight = wgt_rdata;
    assign result     = result_q;

endmodule
